pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Sequencer/hazard controller for the 5-stage MIPS datapath. Drives per-stage rst/en, EXE operand
//  forwarding selects and MEM store-data forwarding. Flushes wrong-path instructions when a jump/branch
//  reaches MEM, freezes the pipe on data-memory wait, and runs a post-reset flush and a debug
//  halt/single-step FSM. Sits beside the datapath in the CPU top; decode is done by the main controller.
// PARAMETERS
//  RST_CYCLES  5  cycles all stage resets stay asserted after rst deasserts (>=1)
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst            in   1   synchronous, active-high reset
//  debug_en       in   1   1 = halt pipeline, advance only on debug_step
//  debug_step     in   1   level; each 0->1 edge (seen while halted) = one advance cycle
//  inst_data_id   in   32  instruction in ID
//  inst_data_exe  in   32  instruction in EXE
//  inst_data_mem  in   32  instruction in MEM
//  regw_addr_mem  in   5   MEM-stage destination register
//  wb_wen_mem     in   1   MEM-stage register write enable
//  is_branch_mem  in   1   MEM instruction redirects PC (jump/branch, taken or not)
//  mem_ren        in   1   data-memory read in MEM
//  mem_wen        in   1   data-memory write in MEM
//  mem_ready      in   1   data memory completes this cycle
//  if_rst,id_rst,exe_rst,mem_rst,wb_rst  out 1 each  stage resets
//  if_en,id_en,exe_en,mem_en,wb_en       out 1 each  stage enables
//  exe_fwd_a_ctrl out  2   EXE rs source: 00 reg, 01 alu_out_mem, 10 mem_din, 11 regw_data_wb
//  exe_fwd_b_ctrl out  2   EXE rt source, same encoding
//  mem_fwd_m      out  1   1 = store data in MEM taken from regw_data_wb
//  halted         out  1   FSM in HALT
// BEHAVIOUR
//  - FSM: FLUSH, RUN, MEM_WAIT, HALT, STEP. rst -> FLUSH, cnt=0. All *_rst=1, *_en=0, fwd=00,
//    mem_fwd_m=0, halted=0 while rst=1 and throughout FLUSH.
//  - FLUSH: cnt++ each cycle; at cnt==RST_CYCLES-1 -> HALT if debug_en, else RUN.
//  - adv = (state RUN or STEP) & ~stall, stall = (mem_ren|mem_wen) & ~mem_ready.
//    All five *_en = adv. No partial freeze; rst outputs stay 0 while frozen.
//  - RUN: stall -> MEM_WAIT; else debug_en -> HALT. MEM_WAIT: mem_ready -> (debug_en ? HALT : RUN).
//    In MEM_WAIT adv=0.
//  - HALT: step edge -> STEP; debug_en=0 -> RUN. STEP: one cycle; stall -> MEM_WAIT, else -> HALT.
//    step_q register for edge detect; reset 0.
//  - Branch flush: when adv & is_branch_mem: id_rst=1, exe_rst=1 same cycle (kills IF and ID
//    wrong-path instrs). if_en=1 loads target into PC. mem_en/wb_en=1. if_rst never asserted outside
//    rst/FLUSH. is_branch_mem while frozen: no flush until the advancing cycle.
//  - WB shadow: regw_addr_wb_q/wb_wen_wb_q <= regw_addr_mem/wb_wen_mem when wb_en. Cleared (0) on
//    rst/FLUSH.
//  - Forwarding (combinational, EXE rs=inst_data_exe[25:21], rt=[20:16]; reg 0 never forwarded):
//    MEM match (wb_wen_mem & regw_addr_mem==src) wins: 10 if MEM opcode is LW, else 01.
//    Else WB match (wb_wen_wb_q & regw_addr_wb_q==src): 11. Else 00.
//  - mem_fwd_m = (MEM opcode SW) & wb_wen_wb_q & regw_addr_wb_q==inst_data_mem[20:16] & !=0.
//  - Load-use needs no stall (mem_din forwarded in same cycle). WB->ID hazard is resolved by
//    regfile write-through; not handled here.
//  - Simultaneous: rst > FLUSH > stall > halt > branch flush.
// STRUCTURE
//  - OP_LW=6'h23, OP_SW=6'h2b, FWD_* encodings, PCTRL_* state codes go in mips_define.vh.
//  - Sub-module fwd_unit: pure-combinational forwarding/mem_fwd_m.
//  - Top holds FSM, counter, step edge detect, WB shadow.
// TESTING
//  - rst 1 cycle, RST_CYCLES=5 -> all *_rst=1 for 6 cycles, then all *_en=1, *_rst=0.
//  - MEM: addiu $3 (wen,addr 3); EXE rs=3 -> fwd_a=01. MEM lw $3 -> 10. Only WB shadow=3 -> 11.
//    $0 -> 00.
//  - MEM sw rt=5, WB shadow addr 5 wen=1 -> mem_fwd_m=1; shadow addr 0 -> 0.
//  - mem_ren=1, mem_ready=0 for 3 cycles -> all en=0 for 3 cycles, MEM_WAIT; ready=1 -> en=1.
//  - is_branch_mem=1 in RUN -> id_rst=exe_rst=1, if_en=1, if_rst=0, one cycle.
//    Same during stall -> deferred.
//  - debug_en=1 -> halted=1, en=0. Two step pulses -> exactly two en=1 cycles.
//    debug_en=0 -> RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared opcodes, forwarding encodings and sequencer states
package pipeline_ctrl_pkg;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_ALU_MEM = 2'b01;
    localparam logic [1:0] FWD_MEM_DIN = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b11;

    typedef enum logic [2:0] {
        PCTRL_FLUSH    = 3'd0,
        PCTRL_RUN      = 3'd1,
        PCTRL_MEM_WAIT = 3'd2,
        PCTRL_HALT     = 3'd3,
        PCTRL_STEP     = 3'd4
    } pctrl_state_t;

    // MEM result beats WB result; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wen_mem,
        input logic [4:0] addr_mem,
        input logic       mem_is_lw,
        input logic       wen_wb,
        input logic [4:0] addr_wb
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != 5'd0) begin
            if (wen_mem && addr_mem == src)
                sel = mem_is_lw ? FWD_MEM_DIN : FWD_ALU_MEM;
            else if (wen_wb && addr_wb == src)
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// rtl/pipeline_ctrl_fwd_unit.sv - combinational EXE operand and MEM store-data forwarding
module pipeline_ctrl_fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] exe_rs,
    input  logic [4:0] exe_rt,
    input  logic [5:0] mem_op,
    input  logic [4:0] mem_rt,
    input  logic [4:0] regw_addr_mem,
    input  logic       wb_wen_mem,
    input  logic [4:0] regw_addr_wb,
    input  logic       wb_wen_wb,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mem_fwd_m
);

    logic mem_is_lw;

    assign mem_is_lw = (mem_op == OP_LW);

    assign fwd_a = fwd_sel(exe_rs, wb_wen_mem, regw_addr_mem, mem_is_lw, wb_wen_wb, regw_addr_wb);
    assign fwd_b = fwd_sel(exe_rt, wb_wen_mem, regw_addr_mem, mem_is_lw, wb_wen_wb, regw_addr_wb);

    assign mem_fwd_m = (mem_op == OP_SW) && wb_wen_wb && (regw_addr_wb == mem_rt)
                     && (mem_rt != 5'd0);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer: reset flush, memory freeze, branch flush, debug step
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug_en,
    input  logic        debug_step,
    input  logic [31:0] inst_data_id,
    input  logic [31:0] inst_data_exe,
    input  logic [31:0] inst_data_mem,
    input  logic [4:0]  regw_addr_mem,
    input  logic        wb_wen_mem,
    input  logic        is_branch_mem,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        mem_ready,
    output logic        if_rst,
    output logic        id_rst,
    output logic        exe_rst,
    output logic        mem_rst,
    output logic        wb_rst,
    output logic        if_en,
    output logic        id_en,
    output logic        exe_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic [1:0]  exe_fwd_a_ctrl,
    output logic [1:0]  exe_fwd_b_ctrl,
    output logic        mem_fwd_m,
    output logic        halted
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    pctrl_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic [4:0]       regw_addr_wb_q;
    logic             wb_wen_wb_q;

    logic       flushing;
    logic       stall;
    logic       adv;
    logic       branch_flush;
    logic       step_edge;
    logic       cnt_last;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       mem_fwd_raw;
    logic       unused_inst_bits;

    assign unused_inst_bits = ^{inst_data_id, inst_data_exe[15:0],
                                inst_data_mem[25:21], inst_data_mem[15:0]};

    assign flushing     = rst || (state == PCTRL_FLUSH);
    assign stall        = (mem_ren || mem_wen) && !mem_ready;
    assign adv          = !rst && (state == PCTRL_RUN || state == PCTRL_STEP) && !stall;
    assign branch_flush = adv && is_branch_mem;
    assign step_edge    = debug_step && !step_q;
    assign cnt_last     = (cnt == CNT_W'(RST_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= PCTRL_FLUSH;
            cnt            <= '0;
            step_q         <= 1'b0;
            regw_addr_wb_q <= 5'd0;
            wb_wen_wb_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= debug_step;
            if (state == PCTRL_FLUSH)
                cnt <= cnt + 1'b1;
            if (state == PCTRL_FLUSH) begin
                regw_addr_wb_q <= 5'd0;
                wb_wen_wb_q    <= 1'b0;
            end else if (adv) begin
                regw_addr_wb_q <= regw_addr_mem;
                wb_wen_wb_q    <= wb_wen_mem;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PCTRL_FLUSH:
                if (cnt_last) state_nxt = debug_en ? PCTRL_HALT : PCTRL_RUN;
            PCTRL_RUN:
                if (stall)         state_nxt = PCTRL_MEM_WAIT;
                else if (debug_en) state_nxt = PCTRL_HALT;
            PCTRL_MEM_WAIT:
                if (mem_ready) state_nxt = debug_en ? PCTRL_HALT : PCTRL_RUN;
            PCTRL_HALT:
                if (step_edge)     state_nxt = PCTRL_STEP;
                else if (!debug_en) state_nxt = PCTRL_RUN;
            PCTRL_STEP:
                state_nxt = stall ? PCTRL_MEM_WAIT : PCTRL_HALT;
            default:
                state_nxt = PCTRL_FLUSH;
        endcase
    end

    pipeline_ctrl_fwd_unit u_fwd (
        .exe_rs        (inst_data_exe[25:21]),
        .exe_rt        (inst_data_exe[20:16]),
        .mem_op        (inst_data_mem[31:26]),
        .mem_rt        (inst_data_mem[20:16]),
        .regw_addr_mem (regw_addr_mem),
        .wb_wen_mem    (wb_wen_mem),
        .regw_addr_wb  (regw_addr_wb_q),
        .wb_wen_wb     (wb_wen_wb_q),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw),
        .mem_fwd_m     (mem_fwd_raw)
    );

    // Branch flush kills the two wrong-path slots (IF->ID, ID->EXE) while IF loads the target.
    always_comb begin
        if_rst         = flushing;
        id_rst         = flushing || branch_flush;
        exe_rst        = flushing || branch_flush;
        mem_rst        = flushing;
        wb_rst         = flushing;
        if_en          = adv;
        id_en          = adv;
        exe_en         = adv;
        mem_en         = adv;
        wb_en          = adv;
        exe_fwd_a_ctrl = flushing ? FWD_REG : fwd_a_raw;
        exe_fwd_b_ctrl = flushing ? FWD_REG : fwd_b_raw;
        mem_fwd_m      = flushing ? 1'b0 : mem_fwd_raw;
        halted         = !rst && (state == PCTRL_HALT);
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

    localparam int RST_CYCLES = 5;

    logic        clk = 1'b0;
    logic        rst, debug_en, debug_step;
    logic [31:0] inst_data_id, inst_data_exe, inst_data_mem;
    logic [4:0]  regw_addr_mem;
    logic        wb_wen_mem, is_branch_mem, mem_ren, mem_wen, mem_ready;
    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic [1:0]  exe_fwd_a_ctrl, exe_fwd_b_ctrl;
    logic        mem_fwd_m, halted;

    always #5 clk = ~clk;

    pipeline_ctrl #(.RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .inst_data_id(inst_data_id), .inst_data_exe(inst_data_exe), .inst_data_mem(inst_data_mem),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .is_branch_mem(is_branch_mem),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_ready(mem_ready),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .exe_fwd_a_ctrl(exe_fwd_a_ctrl), .exe_fwd_b_ctrl(exe_fwd_b_ctrl),
        .mem_fwd_m(mem_fwd_m), .halted(halted)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining flush cycles plus three mode flags; none set means running.
    int         m_flush_left = 0;
    bit         m_halt = 0, m_wait = 0, m_step = 0, m_step_prev = 0;
    logic [4:0] m_wb_addr = 0;
    bit         m_wb_wen = 0;

    int cnt_rst_cycles, cnt_en_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h1234};
    endfunction

    function automatic logic [1:0] want_fwd(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (wb_wen_mem && regw_addr_mem == src) return (inst_data_mem[31:26] == 6'h23) ? 2'd2 : 2'd1;
        if (m_wb_wen && m_wb_addr == src) return 2'd3;
        return 2'd0;
    endfunction

    task automatic tick();
        bit flushing, stall, adv, brk;
        #1;
        flushing = rst || m_flush_left > 0;
        stall    = (mem_ren || mem_wen) && !mem_ready;
        adv      = !flushing && !m_halt && !m_wait && !stall;
        brk      = adv && is_branch_mem;
        check("stage_rst", {27'd0, if_rst, id_rst, exe_rst, mem_rst, wb_rst},
              {27'd0, flushing, flushing || brk, flushing || brk, flushing, flushing});
        check("stage_en", {27'd0, if_en, id_en, exe_en, mem_en, wb_en}, {27'd0, {5{adv}}});
        check("fwd_a", {30'd0, exe_fwd_a_ctrl}, flushing ? 0 : {30'd0, want_fwd(inst_data_exe[25:21])});
        check("fwd_b", {30'd0, exe_fwd_b_ctrl}, flushing ? 0 : {30'd0, want_fwd(inst_data_exe[20:16])});
        check("mem_fwd_m", {31'd0, mem_fwd_m},
              {31'd0, !flushing && inst_data_mem[31:26] == 6'h2b && m_wb_wen
                      && m_wb_addr == inst_data_mem[20:16] && inst_data_mem[20:16] != 0});
        check("halted", {31'd0, halted}, {31'd0, !rst && m_halt && m_flush_left == 0});
        if (if_rst) cnt_rst_cycles++;
        if (if_en)  cnt_en_cycles++;
        @(posedge clk);
        if (rst) begin
            m_flush_left = RST_CYCLES;
            {m_halt, m_wait, m_step, m_step_prev, m_wb_wen} = '0;
            m_wb_addr = 0;
        end else begin
            if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0) m_halt = debug_en;
                m_wb_wen = 0;
                m_wb_addr = 0;
            end else if (m_wait) begin
                if (mem_ready) begin m_wait = 0; m_halt = debug_en; end
            end else if (m_halt) begin
                if (debug_step && !m_step_prev) begin m_halt = 0; m_step = 1; end
                else if (!debug_en) m_halt = 0;
            end else begin
                if (adv) begin m_wb_wen = wb_wen_mem; m_wb_addr = regw_addr_mem; end
                if (stall) begin m_wait = 1; m_step = 0; end
                else if (m_step) begin m_step = 0; m_halt = 1; end
                else if (debug_en) m_halt = 1;
            end
            m_step_prev = debug_step;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        debug_step = 0; is_branch_mem = 0; mem_ren = 0; mem_wen = 0; mem_ready = 0;
        wb_wen_mem = 0; regw_addr_mem = 0;
        inst_data_id = 0; inst_data_exe = 0; inst_data_mem = 0;
    endtask

    initial begin
        rst = 1; debug_en = 0;
        idle_inputs();
        @(negedge clk);

        // Reset and post-reset flush
        cnt_rst_cycles = 0;
        tick();
        rst = 0;
        repeat (RST_CYCLES + 2) tick();
        check("flush_len", cnt_rst_cycles, RST_CYCLES + 1);

        // Forwarding: MEM ALU result, MEM load, WB shadow, register 0
        inst_data_exe = mk(6'h00, 5'd3, 5'd7);
        inst_data_mem = mk(6'h09, 5'd1, 5'd3); wb_wen_mem = 1; regw_addr_mem = 3; tick();
        inst_data_mem = mk(6'h23, 5'd1, 5'd3); tick();
        wb_wen_mem = 0; inst_data_mem = mk(6'h00, 5'd0, 5'd0); tick();
        inst_data_exe = mk(6'h00, 5'd0, 5'd0); wb_wen_mem = 1; regw_addr_mem = 0; tick();

        // Store-data forwarding from WB shadow
        regw_addr_mem = 5; wb_wen_mem = 1; tick();
        wb_wen_mem = 0; inst_data_mem = mk(6'h2b, 5'd2, 5'd5); tick();
        tick();
        inst_data_mem = mk(6'h2b, 5'd2, 5'd0); tick();

        // Data-memory freeze
        idle_inputs();
        cnt_en_cycles = 0;
        mem_ren = 1; mem_ready = 0; repeat (3) tick();
        check("stall_en_zero", cnt_en_cycles, 0);
        mem_ready = 1; tick();
        mem_ren = 0; mem_ready = 0; tick();

        // Branch flush in RUN, then deferred while frozen
        is_branch_mem = 1; tick();
        is_branch_mem = 0; tick();
        is_branch_mem = 1; mem_wen = 1; repeat (2) tick();
        mem_ready = 1; tick();
        mem_wen = 0; mem_ready = 0; tick();
        is_branch_mem = 0; tick();

        // Debug halt and two single steps
        debug_en = 1; repeat (3) tick();
        cnt_en_cycles = 0;
        repeat (2) begin
            debug_step = 1; tick();
            debug_step = 0; repeat (2) tick();
        end
        check("step_en_count", cnt_en_cycles, 2);
        debug_en = 0; repeat (2) tick();

        // Randomized traffic including occasional resets and debug sessions
        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) debug_en = ~debug_en;
            debug_step    = ($urandom_range(0, 3) == 0);
            inst_data_id  = $urandom;
            inst_data_exe = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            case ($urandom_range(0, 3))
                0:       inst_data_mem = mk(6'h23, 5'($urandom), 5'($urandom_range(0, 7)));
                1:       inst_data_mem = mk(6'h2b, 5'($urandom), 5'($urandom_range(0, 7)));
                default: inst_data_mem = mk(6'($urandom), 5'($urandom), 5'($urandom_range(0, 7)));
            endcase
            regw_addr_mem = 5'($urandom_range(0, 7));
            wb_wen_mem    = 1'($urandom);
            is_branch_mem = ($urandom_range(0, 5) == 0);
            mem_ren       = ($urandom_range(0, 3) == 0);
            mem_wen       = ($urandom_range(0, 5) == 0);
            mem_ready     = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
